// File: rtl/spi_slave_if.sv
// SPI slave bundle: serial pins toward the master plus the parallel
// transmit/receive side toward local logic.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  // serial side
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  // parallel side
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  tx_underrun;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk (clk >= 4x sclk).
// One-entry transmit buffer; a frame with nothing buffered shifts out zeros
// and flags tx_underrun. Raising cs_n mid-frame discards the partial word.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, next_state;

  logic sclk_meta, sclk_s, sclk_d;
  logic cs_meta, cs_s, cs_d;
  logic mosi_meta, mosi_s;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic frame_load, frame_abort, rx_sample, tx_shift_en;

  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  buf_full;
  logic                  tx_underrun_q;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  frame_done;

  // Two-flop synchronizers plus a delayed copy for edge detection; reset to
  // the bus idle levels so leaving reset never fakes an edge on an idle bus.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      cs_meta   <= 1'b1; cs_s   <= 1'b1; cs_d   <= 1'b1;
      mosi_meta <= 1'b0; mosi_s <= 1'b0;
    end else begin
      sclk_meta <= bus.sclk; sclk_s <= sclk_meta; sclk_d <= sclk_s;
      cs_meta   <= bus.cs_n; cs_s   <= cs_meta;   cs_d   <= cs_s;
      mosi_meta <= bus.mosi; mosi_s <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle frame actions; a cs_n rise outranks any sclk
  // edge seen in the same cycle.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    frame_load  = 1'b0;
    frame_abort = 1'b0;
    rx_sample   = 1'b0;
    tx_shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state = ACTIVE;
          frame_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          next_state  = IDLE;
          frame_abort = 1'b1;
        end else begin
          rx_sample = sclk_rise;
          if (sclk_fall) begin
            frame_load  = frame_done;
            tx_shift_en = ~frame_done;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Transmit path: frame load from the buffer (or zeros on underrun), shift
  // on sclk fall, and buffer writes. A write in the same cycle as a load of
  // an empty buffer is kept for the next frame because it is applied last.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift      <= '0;
      tx_buf        <= '0;
      buf_full      <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_underrun_q <= 1'b0;
      if (frame_load) begin
        if (buf_full) begin
          tx_shift <= tx_buf;
          buf_full <= 1'b0;
        end else begin
          tx_shift      <= '0;
          tx_underrun_q <= 1'b1;
        end
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
      if (bus.tx_valid && !buf_full) begin
        tx_buf   <= bus.tx_data;
        buf_full <= 1'b1;
      end
    end
  end

  // Receive path: sample on sclk rise, publish the word with a one-cycle
  // pulse on the last bit, and remember that the next fall starts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (frame_abort) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else if (frame_load) begin
        frame_done <= 1'b0;
      end else if (rx_sample) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= '0;
          rx_data_q  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
          rx_valid_q <= 1'b1;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy        = (state == ACTIVE);
  assign bus.miso_oe     = (state == ACTIVE);
  assign bus.miso        = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
  assign bus.tx_ready    = ~buf_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: sclk = clk/8, stimulus changes and sampling
// on clk falling edges, pulse counters kept by a small monitor.
module tb_spi_slave;

  logic clk = 1'b0;
  logic reset;

  spi_slave_if #(.DATA_WIDTH(8)) bus ();

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int dbl_cnt = 0;
  logic prev_rxv = 1'b0;
  logic prev_ur  = 1'b0;
  logic [7:0] seen;

  // Count rx_valid / tx_underrun pulses and any pulse longer than one cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid) rx_cnt++;
      if (bus.tx_underrun) ur_cnt++;
      if ((bus.rx_valid && prev_rxv) || (bus.tx_underrun && prev_ur)) dbl_cnt++;
    end
    prev_rxv = bus.rx_valid;
    prev_ur  = bus.tx_underrun;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic start_frame();
    bus.cs_n = 1'b0;
    half();
  endtask

  task automatic end_frame();
    bus.cs_n = 1'b1;
    half();
    bus.sclk = 1'b0;
    half();
  endtask

  // Shift nbits of a word MSB first; cont=1 opens with the sclk fall that
  // finishes the previous back-to-back frame. miso is sampled before each rise.
  task automatic xfer(input logic [7:0] w, input int nbits, input bit cont,
                      output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 || cont) bus.sclk = 1'b0;
      bus.mosi = w[7-i];
      half();
      got = {got[6:0], bus.miso};
      bus.sclk = 1'b1;
      half();
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_miso_oe", bus.miso_oe, 0);
    check("rst_miso", bus.miso, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_underrun", bus.tx_underrun, 0);
    reset = 1'b0;
    half();

    // basic frame: tx 0xA5, rx 0x3C
    write_tx(8'hA5);
    check("a5_tx_ready_full", bus.tx_ready, 0);
    start_frame();
    check("a5_busy", bus.busy, 1);
    check("a5_miso_oe", bus.miso_oe, 1);
    check("a5_tx_ready_loaded", bus.tx_ready, 1);
    xfer(8'h3C, 8, 1'b0, seen);
    check("a5_miso_bits", seen, 8'hA5);
    end_frame();
    check("a5_rx_data", bus.rx_data, 8'h3C);
    check("a5_rx_cnt", rx_cnt, 1);
    check("a5_ur_cnt", ur_cnt, 0);
    check("a5_busy_idle", bus.busy, 0);
    check("a5_oe_idle", bus.miso_oe, 0);
    check("a5_miso_idle", bus.miso, 0);

    // back-to-back frames, second word written during frame 1
    write_tx(8'h81);
    start_frame();
    write_tx(8'h7E);
    xfer(8'h5A, 8, 1'b0, seen);
    check("b2b_miso1", seen, 8'h81);
    check("b2b_rx1", bus.rx_data, 8'h5A);
    check("b2b_rx_cnt1", rx_cnt, 2);
    xfer(8'hC3, 8, 1'b1, seen);
    check("b2b_miso2", seen, 8'h7E);
    end_frame();
    check("b2b_rx2", bus.rx_data, 8'hC3);
    check("b2b_rx_cnt2", rx_cnt, 3);
    check("b2b_ur_cnt", ur_cnt, 0);
    check("b2b_tx_ready", bus.tx_ready, 1);

    // empty buffer -> underrun, zeros out, receive unaffected
    start_frame();
    check("ur_pulse_at_cs", ur_cnt, 1);
    xfer(8'h96, 8, 1'b0, seen);
    check("ur_miso_zero", seen, 8'h00);
    end_frame();
    check("ur_rx_data", bus.rx_data, 8'h96);
    check("ur_rx_cnt", rx_cnt, 4);
    check("ur_single", ur_cnt, 1);

    // abort after 5 rises, then a clean frame
    write_tx(8'h3E);
    start_frame();
    xfer(8'hFF, 5, 1'b0, seen);
    end_frame();
    check("abort_busy", bus.busy, 0);
    check("abort_oe", bus.miso_oe, 0);
    check("abort_rx_cnt", rx_cnt, 4);
    check("abort_rx_hold", bus.rx_data, 8'h96);
    write_tx(8'hE7);
    start_frame();
    xfer(8'h4B, 8, 1'b0, seen);
    end_frame();
    check("abort_next_miso", seen, 8'hE7);
    check("abort_next_rx", bus.rx_data, 8'h4B);
    check("abort_next_rx_cnt", rx_cnt, 5);

    // sclk activity with cs_n high is ignored; write while full is ignored
    write_tx(8'h6C);
    write_tx(8'h11);
    for (int i = 0; i < 8; i++) begin
      bus.sclk = 1'b1;
      bus.mosi = i[0];
      half();
      bus.sclk = 1'b0;
      half();
    end
    check("idle_sclk_oe", bus.miso_oe, 0);
    check("idle_sclk_miso", bus.miso, 0);
    check("idle_sclk_rx_cnt", rx_cnt, 5);
    check("idle_sclk_tx_ready", bus.tx_ready, 0);
    start_frame();
    xfer(8'hF0, 8, 1'b0, seen);
    end_frame();
    check("idle_sclk_miso_word", seen, 8'h6C);
    check("idle_sclk_rx", bus.rx_data, 8'hF0);

    // write in the exact cycle of a load with an empty buffer
    @(negedge clk);
    bus.cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.tx_data  = 8'h5C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    half();
    check("coll_ur_cnt", ur_cnt, 2);
    check("coll_tx_ready", bus.tx_ready, 0);
    xfer(8'hA0, 8, 1'b0, seen);
    check("coll_miso_zero", seen, 8'h00);
    xfer(8'h0F, 8, 1'b1, seen);
    check("coll_miso_kept", seen, 8'h5C);
    end_frame();
    check("coll_rx", bus.rx_data, 8'h0F);
    check("coll_rx_cnt", rx_cnt, 8);
    check("coll_ur_final", ur_cnt, 2);

    // reset after 3 bits of a frame
    write_tx(8'h33);
    start_frame();
    xfer(8'hAA, 3, 1'b0, seen);
    reset    = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_busy", bus.busy, 0);
    check("mrst_oe", bus.miso_oe, 0);
    check("mrst_miso", bus.miso, 0);
    check("mrst_tx_ready", bus.tx_ready, 1);
    check("mrst_rx_data", bus.rx_data, 0);
    check("mrst_rx_valid", bus.rx_valid, 0);
    check("mrst_underrun", bus.tx_underrun, 0);
    reset = 1'b0;
    half();
    write_tx(8'hC9);
    start_frame();
    xfer(8'h2D, 8, 1'b0, seen);
    end_frame();
    check("mrst_next_miso", seen, 8'hC9);
    check("mrst_next_rx", bus.rx_data, 8'h2D);
    check("mrst_next_rx_cnt", rx_cnt, 9);

    check("pulse_width", dbl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame length in bits (min 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port mosi  input  1  SPI master-out data, asynchronous.
REQ-007 SHALL have port miso  output  1  SPI slave-out data.
REQ-008 SHALL have port miso_oe  output  1  miso output enable for external tri-state buffer.
REQ-009 SHALL have port tx_data  input  DATA_WIDTH  word to transmit.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid.
REQ-011 SHALL have port tx_ready  output  1  one-entry transmit buffer empty.
REQ-012 SHALL have port rx_data  output  DATA_WIDTH  last complete received word.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse, new rx_data.
REQ-014 SHALL have port busy  output  1  frame in progress (state ACTIVE).
REQ-015 SHALL have port tx_underrun  output  1  one-cycle pulse, frame loaded with an empty buffer.

Function
REQ-016 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers of equal depth; all decisions use synchronized values.
REQ-017 SHALL detect sclk rise/fall and cs_n fall/rise by comparing each synchronized signal to its one-cycle-delayed copy.
REQ-018 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first; correct operation requires clk frequency >= 4x sclk.
REQ-019 SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on detected cs_n fall, ACTIVE->IDLE on detected cs_n rise.
REQ-020 SHALL ignore sclk edges and mosi while in IDLE.
REQ-021 SHALL perform a frame load on entry to ACTIVE and on the first sclk fall after a completed frame while cs_n stays low.
REQ-022 Frame load: shift register <= buffer and buffer marked empty if full; else shift register <= 0 and tx_underrun pulses for that cycle.
REQ-023 SHALL drive miso = shift register MSB while ACTIVE; on each sclk fall not a frame load, shift left by one.
REQ-024 SHALL sample synchronized mosi into the receive shift register on each sclk rise in ACTIVE and increment a bit counter modulo DATA_WIDTH.
REQ-025 On the DATA_WIDTH-th rise, rx_data SHALL update to the full word (first bit in MSB) and rx_valid SHALL be 1 for exactly one cycle, in the same clock edge that captures the last bit.
REQ-026 rx_data SHALL hold its value until the next completed frame.
REQ-027 tx_ready SHALL be 1 while the buffer is empty; tx_valid && tx_ready writes tx_data into the buffer; tx_valid while tx_ready=0 SHALL be ignored.
REQ-028 Write and frame load in the same cycle with empty buffer: load SHALL use zeros (underrun), and the written word SHALL remain buffered for the next frame.
REQ-029 miso_oe SHALL equal 1 exactly while ACTIVE; miso SHALL be 0 whenever miso_oe=0.
REQ-030 cs_n rise mid-frame SHALL abort: bit counter cleared, partial word discarded, no rx_valid, buffer contents unchanged.

Reset
REQ-031 While reset=1: state IDLE, miso 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, busy 0, tx_underrun 0, bit counter 0, buffer empty, synchronizers cleared to cs_n=1, sclk=0, mosi=0.
REQ-032 Reset asserted mid-frame SHALL apply REQ-031 on the next clk edge; the frame in progress SHALL be lost; a new frame requires a fresh cs_n fall.

Verification
REQ-033 Load tx_data=0xA5, frame with mosi=0x3C, sclk=clk/8 -> miso shows 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse; tx_ready back to 1 after load.
REQ-034 Two back-to-back frames, cs_n held low, buffer 0x81 then 0x7E written during frame 1 -> miso 0x81 then 0x7E, two rx_valid pulses, no tx_underrun.
REQ-035 Frame with empty buffer -> tx_underrun single pulse at cs_n fall, miso all 0, rx still captured correctly.
REQ-036 cs_n raised after 5 sclk rises -> no rx_valid, busy and miso_oe drop to 0, next full frame receives correct word.
REQ-037 sclk toggling with cs_n high -> no rx_valid, miso_oe 0, buffer unchanged.
REQ-038 reset pulsed after 3 bits of a frame -> all outputs at REQ-031 values, tx_ready 1, subsequent frame correct.
